// File: rtl/btn_conditioner.sv
// Push-button and mode-switch conditioner.
// Each raw input is synchronized and debounced. Buttons raise one-shot events
// on press; the increment and decrement buttons also auto-repeat while held.
// Events wait in a pending set until the consumer takes them with tick. The
// lowest-index pending bit is presented first. A mode-switch change flushes
// all pending events and restarts the repeat timers.
module btn_conditioner #(
  parameter int DB_CYCLES  = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  input  logic [1:0] sw_raw,
  input  logic       tick,
  output logic [2:0] btn_evt,
  output logic [1:0] sw_stable,
  output logic [2:0] btn_level
);

  localparam int N_IN    = 5;
  localparam int MAX_AB  = (DB_CYCLES > REP_DELAY) ? DB_CYCLES : REP_DELAY;
  localparam int MAX_CNT = (MAX_AB > REP_PERIOD) ? MAX_AB : REP_PERIOD;
  // Wide enough to hold the largest terminal count without wrapping.
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REP_PERIOD - 1);

  // Switches occupy the upper two bits, so bit order matches the outputs.
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync1_q, sync1_d;
  logic [N_IN-1:0] sync2_q, sync2_d;
  logic [N_IN-1:0] stable;

  logic [2:0] level_q, level_d;
  logic [1:0] sw_q, sw_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] evt_q, evt_d;
  logic [2:0] rep_fire;
  logic [2:0] raise;
  logic       sw_change;

  assign raw_in = {sw_raw, btn_raw};

  // Detect a new switch level in the same cycle that it becomes the output.
  assign sw_change = (stable[4:3] != sw_q);

  genvar gi;

  // One debounce counter and one accepted level per synchronized input.
  for (gi = 0; gi < N_IN; gi++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stab_q, stab_d;

    // Count consecutive mismatches and accept the new level after DB_CYCLES of them.
    always_comb begin
      cnt_d  = '0;
      stab_d = stab_q;
      if (sync2_q[gi] != stab_q) begin
        if (cnt_q == DB_LAST) begin
          stab_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        stab_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        stab_q <= stab_d;
      end
    end

    assign stable[gi] = stab_q;
  end

  // Restore-default never repeats.
  assign rep_fire[0] = 1'b0;

  // Auto-repeat timers, one each for increment and decrement.
  for (gi = 1; gi < 3; gi++) begin : g_rep
    logic [CW-1:0] hold_q, hold_d;
    logic          phase_q, phase_d;  // 0: initial delay, 1: periodic repeat
    logic          fire;

    // Time the held button: first event after REP_DELAY, then every REP_PERIOD.
    always_comb begin
      hold_d  = '0;
      phase_d = 1'b0;
      fire    = 1'b0;
      if (level_q[gi] && !sw_change) begin
        hold_d  = hold_q + CW'(1);
        phase_d = phase_q;
        if ((!phase_q && hold_q == DELAY_LAST) ||
            ( phase_q && hold_q == PERIOD_LAST)) begin
          fire    = 1'b1;
          hold_d  = '0;
          phase_d = 1'b1;
        end
      end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q  <= '0;
        phase_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        phase_q <= phase_d;
      end
    end

    assign rep_fire[gi] = fire;
  end

  // Synchronizer chain, registered outputs, and pending-event bookkeeping.
  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    level_d   = stable[2:0];
    sw_d      = stable[4:3];
    raise     = (level_d & ~level_q) | rep_fire;
    pending_d = pending_q;
    // Retire only the presented event; a new raise of that bit wins below.
    if (tick) begin
      pending_d = pending_d & ~evt_q;
    end
    pending_d = pending_d | raise;
    if (sw_change) begin
      pending_d = '0;
    end
    // Present the lowest-index pending bit.
    evt_d = pending_d & (~pending_d + 3'd1);
  end

  // Main state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      sw_q      <= '0;
      pending_q <= '0;
      evt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      sw_q      <= sw_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
    end
  end

  assign btn_evt   = evt_q;
  assign btn_level = level_q;
  assign sw_stable = sw_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner. Directed scenarios use literal expectations,
// and a timeline model checks every cycle.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [1:0] sw_raw;
  logic       tick;
  logic [2:0] btn_evt;
  logic [2:0] btn_level;
  logic [1:0] sw_stable;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .tick     (tick),
    .btn_evt  (btn_evt),
    .sw_stable(sw_stable),
    .btn_level(btn_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Returns the lowest-index set bit, or zero.
  function automatic logic [2:0] first_set(input logic [2:0] p);
    for (int i = 0; i < 3; i++) begin
      if (p[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  // ---------------- timeline model ----------------
  // r_hist[k] holds the raw inputs sampled at edge k. A level is accepted at
  // edge k once samples k-2-DB+1 .. k-2 all disagree with it. It must also be
  // at least DB edges since the previous acceptance or reset.
  int         edge_n = 0;
  logic [4:0] r_hist [0:8191];
  logic [4:0] stab_m;
  int         last_chg [5];
  logic [2:0] level_m;
  logic [1:0] sw_m;
  logic [2:0] pend_m;
  int         origin [3];

  always @(posedge clk) begin : model
    logic [2:0] raise;
    logic [2:0] p;
    logic [2:0] nl;
    logic [1:0] ns;
    logic       swc;
    logic       ok;
    int         k;
    edge_n = edge_n + 1;
    k = edge_n;
    if (rst) begin
      r_hist[k]     = '0;
      r_hist[k - 1] = '0;
      stab_m  = '0;
      level_m = '0;
      sw_m    = '0;
      pend_m  = '0;
      for (int j = 0; j < 5; j++) last_chg[j] = k;
      for (int i = 0; i < 3; i++) origin[i] = k;
    end else begin
      r_hist[k] = {sw_raw, btn_raw};
      nl  = stab_m[2:0];
      ns  = stab_m[4:3];
      swc = (ns != sw_m);
      raise = nl & ~level_m;
      for (int i = 1; i < 3; i++) begin
        if (level_m[i] && (k - origin[i] >= RD) && ((k - origin[i] - RD) % RP == 0))
          raise[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if ((nl[i] && !level_m[i]) || swc) origin[i] = k;
      end
      p = pend_m;
      if (tick) p = p & ~first_set(pend_m);
      p = p | raise;
      if (swc) p = '0;
      pend_m  = p;
      level_m = nl;
      sw_m    = ns;
      for (int j = 0; j < 5; j++) begin
        if (k - last_chg[j] >= DB) begin
          ok = 1'b1;
          for (int m = 0; m < DB; m++) begin
            if (r_hist[k - 2 - m][j] == stab_m[j]) ok = 1'b0;
          end
          if (ok) begin
            stab_m[j]   = ~stab_m[j];
            last_chg[j] = k;
          end
        end
      end
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("model_evt",   32'(btn_evt),   32'(first_set(pend_m)));
      check("model_level", 32'(btn_level), 32'(level_m));
      check("model_sw",    32'(sw_stable), 32'(sw_m));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int times [8];
    int nev;
    int first;
    rst = 1'b1; btn_raw = '0; sw_raw = '0; tick = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_evt",   32'(btn_evt),   0);
    check("reset_level", 32'(btn_level), 0);
    check("reset_sw",    32'(sw_stable), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Bounce btn[1] in 2-cycle runs, then hold it high.
    for (int c = 0; c < 10; c++) begin
      btn_raw[1] = (c % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        check("bounce_quiet", 32'({btn_level, btn_evt}), 0);
      end
    end
    btn_raw[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("db_latency_early", 32'(btn_evt), 0);
    @(negedge clk);
    check("db_latency_evt", 32'(btn_evt), 32'b010);
    check("db_level", 32'(btn_level), 32'b010);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("tick_clear", 32'(btn_evt), 0);
    btn_raw[1] = 1'b0;
    repeat (12) @(negedge clk);

    // Hold btn[2] for 45 cycles without tick.
    btn_raw[2] = 1'b1;
    repeat (7) @(negedge clk);
    check("hold_first", 32'(btn_evt), 32'b100);
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      check("hold_no_tick_const", 32'(btn_evt), 32'b100);
    end
    btn_raw[2] = 1'b0;
    repeat (12) @(negedge clk);
    check("still_pending", 32'(btn_evt), 32'b100);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("consume_pending", 32'(btn_evt), 0);
    repeat (4) @(negedge clk);

    // Hold btn[2] for 45 cycles with tick asserted every cycle.
    nev = 0;
    tick = 1'b1;
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 45) btn_raw[2] = 1'b0;
      if (btn_evt != 3'b000) begin
        if (nev < 8) times[nev] = c;
        nev++;
      end
    end
    tick = 1'b0;
    check("rep_count", 32'(nev), 5);
    check("rep_press_latency", 32'(times[0]), 7);
    check("rep_delay", 32'(times[1] - times[0]), 20);
    check("rep_period1", 32'(times[2] - times[0]), 28);
    check("rep_period2", 32'(times[3] - times[0]), 36);
    repeat (4) @(negedge clk);

    // Press btn[0] and btn[1] together; btn[0] is held for about 100 cycles.
    btn_raw[1:0] = 2'b11;
    repeat (7) @(negedge clk);
    check("prio_first", 32'(btn_evt), 32'b001);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("prio_second", 32'(btn_evt), 32'b010);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("prio_empty", 32'(btn_evt), 0);
    btn_raw[1] = 1'b0;
    repeat (90) @(negedge clk);
    check("no_repeat_btn0", 32'(btn_evt), 0);
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Tick coincides with a repeat of the presented bit.
    btn_raw[2] = 1'b1;
    repeat (7) @(negedge clk);
    check("merge_first", 32'(btn_evt), 32'b100);
    repeat (19) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("tick_merge_keep", 32'(btn_evt), 32'b100);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("tick_after_merge", 32'(btn_evt), 0);
    btn_raw[2] = 1'b0;
    repeat (12) @(negedge clk);
    tick = 1'b1; repeat (2) @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);

    // A pending event is flushed when the switch level changes.
    btn_raw[1] = 1'b1;
    repeat (7) @(negedge clk);
    check("sw_pre_evt", 32'(btn_evt), 32'b010);
    btn_raw[1] = 1'b0;
    sw_raw = 2'b01;
    repeat (6) @(negedge clk);
    check("sw_before", 32'({sw_stable, btn_evt}), 32'b00_010);
    @(negedge clk);
    check("sw_after_stable", 32'(sw_stable), 32'b01);
    check("sw_clears_evt", 32'(btn_evt), 0);
    sw_raw = 2'b00;
    repeat (10) @(negedge clk);
    check("sw_back", 32'(sw_stable), 0);

    // Reset while btn[2] is held and repeating.
    btn_raw[2] = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("rst_mid_zero", 32'({btn_evt, btn_level, sw_stable}), 0);
    repeat (6) @(negedge clk);
    check("rst_repress_early", 32'(btn_evt), 0);
    @(negedge clk);
    check("rst_repress_evt", 32'(btn_evt), 32'b100);
    tick = 1'b1;
    first = -1;
    for (int c = 8; c <= 35; c++) begin
      @(negedge clk);
      if (btn_evt != 3'b000 && first < 0) first = c;
    end
    check("rst_repeat_restart", 32'(first), 27);
    btn_raw[2] = 1'b0;
    repeat (15) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
